bus_cycle_seq: RTL and testbench

//  Bus transaction sequencer; sits directly upstream of the address register.

---
 rtl/bus_cycle_seq_pkg.sv | 36 +++
 rtl/bus_ws_timer.sv | 27 ++
 rtl/bus_cycle_seq.sv | 149 ++++++++++++++
 tb/tb_bus_cycle_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_cycle_seq_pkg.sv
// Shared definitions for the bus transaction sequencer: state codes, default
// timing parameters and small decode helpers. BUS_TIMEOUT_EN widens the timer.
package bus_cycle_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  localparam int DEF_MIN_WS  = 1;
  localparam int DEF_TIMEOUT = 255;

`ifdef BUS_TIMEOUT_EN
  localparam int TIMER_W = 8;
`else
  localparam int TIMER_W = 4;
`endif

  function automatic logic params_ok(input int min_ws, input int timeout);
    return (min_ws >= 1) && (min_ws <= 15) && (timeout >= 1) && (timeout <= 255);
  endfunction

  // Address strobe covers every cycle of a transaction after IDLE.
  function automatic logic addr_phase(input state_t s);
    return (s != ST_IDLE);
  endfunction

  // Data strobe is only low while the data phase is open (STROBE or WAIT).
  function automatic logic data_phase(input state_t s);
    return (s == ST_STROBE) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/bus_ws_timer.sv
// Loadable down-counter for strobe/wait cycle counts.
// zero is high on the terminal cycle of a loaded count (count value 0).
module bus_ws_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_cycle_seq.sv
// Bus transaction sequencer: one-cycle start -> nmem/nio address phase, nr/nw
// data phase with wait states, done pulse. BUS_TIMEOUT_EN adds a WAIT timeout with berr.
module bus_cycle_seq
  import bus_cycle_seq_pkg::*;
#(
  parameter int MIN_WS  = DEF_MIN_WS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic nreset,
  input  logic start,
  input  logic io,
  input  logic write,
  input  logic nwaitext,
  output logic nmem,
  output logic nio,
  output logic nr,
  output logic nw,
  output logic busy,
  output logic done,
  output logic berr
);

  if (!params_ok(MIN_WS, TIMEOUT)) begin : g_param_err
    $error("bus_cycle_seq: MIN_WS must be 1..15 and TIMEOUT 1..255");
  end

  state_t state, state_next;
  logic   io_lat, io_next;
  logic   write_lat, write_next;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_zero;

`ifdef BUS_TIMEOUT_EN
  logic timeout_hit;
`endif

  bus_ws_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk    (clk),
    .nreset (nreset),
    .load   (timer_load),
    .value  (timer_val),
    .zero   (timer_zero)
  );

  always_comb begin
    state_next = state;
    io_next    = io_lat;
    write_next = write_lat;
    timer_load = 1'b0;
    timer_val  = TIMER_W'(MIN_WS - 1);
`ifdef BUS_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_ADDR;
          io_next    = io;
          write_next = write;
        end
      end
      ST_ADDR: begin
        state_next = ST_STROBE;
        timer_load = 1'b1;
        timer_val  = TIMER_W'(MIN_WS - 1);
      end
      ST_STROBE: begin
        if (timer_zero) begin
          if (nwaitext) begin
            state_next = ST_HOLD;
          end else begin
            state_next = ST_WAIT;
`ifdef BUS_TIMEOUT_EN
            timer_load = 1'b1;
            timer_val  = TIMER_W'(TIMEOUT - 1);
`endif
          end
        end
      end
      ST_WAIT: begin
        if (nwaitext) begin
          state_next = ST_HOLD;
`ifdef BUS_TIMEOUT_EN
        end else if (timer_zero) begin
          // Device never released the bus: close the cycle and flag it.
          state_next  = ST_HOLD;
          timeout_hit = 1'b1;
`endif
        end
      end
      ST_HOLD: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= ST_IDLE;
      io_lat    <= 1'b0;
      write_lat <= 1'b0;
    end else begin
      state     <= state_next;
      io_lat    <= io_next;
      write_lat <= write_next;
    end
  end

  // Outputs are decoded from the next state so they leave the flops glitch-free
  // in the same cycle the state register takes that value.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      nmem <= 1'b1;
      nio  <= 1'b1;
      nr   <= 1'b1;
      nw   <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      nmem <= !(addr_phase(state_next) && !io_next);
      nio  <= !(addr_phase(state_next) && io_next);
      nr   <= !(data_phase(state_next) && !write_next);
      nw   <= !(data_phase(state_next) && write_next);
      busy <= (state_next != ST_IDLE);
      done <= (state_next == ST_HOLD);
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      berr <= 1'b0;
    end else begin
      berr <= timeout_hit;
    end
  end
`else
  assign berr = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cycle_seq.sv
// Randomised and directed bench for bus_cycle_seq; expected outputs come from a
// transaction-level model that computes each transaction's HOLD cycle arithmetically.
module tb_bus_cycle_seq;

  localparam int MIN_WS  = 1;
  localparam int TIMEOUT = 16;
  localparam int MAXC    = 1200;
  localparam int INF     = 32'h3fff_ffff;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic start = 1'b0, io = 1'b0, write = 1'b0, nwaitext = 1'b1;
  logic nmem, nio, nr, nw, busy, done, berr;

  bus_cycle_seq #(
    .MIN_WS  (MIN_WS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .nreset   (nreset),
    .start    (start),
    .io       (io),
    .write    (write),
    .nwaitext (nwaitext),
    .nmem     (nmem),
    .nio      (nio),
    .nr       (nr),
    .nw       (nw),
    .busy     (busy),
    .done     (done),
    .berr     (berr)
  );

  always #5 clk = ~clk;

  logic st_a  [0:MAXC-1];
  logic io_a  [0:MAXC-1];
  logic wr_a  [0:MAXC-1];
  logic nwt_a [0:MAXC-1];
  int   n_cyc;
  logic tail_nwt;
  int   cyc;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  function automatic logic get_nwt(input int t);
    if (t < n_cyc) return nwt_a[t];
    return tail_nwt;
  endfunction

  // HOLD cycle of a transaction started at c0: last STROBE cycle is c0+1+MIN_WS,
  // then WAIT cycles until nwaitext=1 is sampled (or the TIMEOUT-th WAIT cycle).
  task automatic hold_cycle(input int c0, output int h, output logic be);
    int se;
    se = c0 + 1 + MIN_WS;
    be = 1'b0;
    h  = INF;
    if (get_nwt(se)) begin
      h = se + 1;
    end else begin
      for (int k = 1; k <= 5000; k++) begin
        if (get_nwt(se + k)) begin
          h = se + k + 1;
          break;
        end
`ifdef BUS_TIMEOUT_EN
        if (k == TIMEOUT) begin
          h  = se + k + 1;
          be = 1'b1;
          break;
        end
`endif
      end
    end
  endtask

  task automatic clear_stim(input int n);
    n_cyc    = n;
    tail_nwt = 1'b1;
    for (int i = 0; i < MAXC; i++) begin
      st_a[i]  = 1'b0;
      io_a[i]  = 1'($urandom_range(0, 1));
      wr_a[i]  = 1'($urandom_range(0, 1));
      nwt_a[i] = 1'b1;
    end
  endtask

  task automatic check_invariants();
    chk("invariant", {5'b0, ~(~nmem & ~nio), ~(~nr & ~nw), ~((~nr | ~nw) & nmem & nio)}, 8'b0000_0111);
  endtask

  task automatic run_seq(input int ncyc);
    logic have;
    int   c0, h;
    logic tio, twr, tbe;
    logic inb, dat;
    logic [6:0] exp;
    have = 1'b0; c0 = 0; h = -1; tio = 1'b0; twr = 1'b0; tbe = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      #1;
      cyc = n;
      inb = have && (n > c0) && (n <= h);
      dat = have && (n >= c0 + 2) && (n <= h - 1);
      exp = {~(inb & ~tio), ~(inb & tio), ~(dat & ~twr), ~(dat & twr),
             inb, have && (n == h), have && (n == h) && tbe};
      chk("outs", {1'b0, nmem, nio, nr, nw, busy, done, berr}, {1'b0, exp});
      check_invariants();
      if (st_a[n] && (!have || n > h)) begin
        have = 1'b1;
        c0   = n;
        tio  = io_a[n];
        twr  = wr_a[n];
        hold_cycle(n, h, tbe);
      end
      start    = st_a[n];
      io       = io_a[n];
      write    = wr_a[n];
      nwaitext = get_nwt(n);
    end
    start    = 1'b0;
    nwaitext = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic random_run(input int n);
    int run_left;
    clear_stim(n);
    run_left = 0;
    for (int i = 0; i < n; i++) begin
      if (i < n - 40) st_a[i] = ($urandom_range(0, 3) == 0);
      if (run_left > 0) begin
        nwt_a[i] = 1'b0;
        run_left--;
      end else if (i < n - 40 && $urandom_range(0, 19) == 0) begin
        run_left = $urandom_range(1, 20);
        nwt_a[i] = 1'b0;
      end else begin
        nwt_a[i] = (i >= n - 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
    end
    run_seq(n);
  endtask

  initial begin
    cyc = -1;
    // Reset held with random inputs.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("reset", {1'b0, nmem, nio, nr, nw, busy, done, berr}, 8'b0111_1000);
      start    = 1'($urandom_range(0, 1));
      io       = 1'($urandom_range(0, 1));
      write    = 1'($urandom_range(0, 1));
      nwaitext = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    nwaitext = 1'b1;
    @(negedge clk);
    nreset = 1'b1;

    // Memory read, zero waits.
    clear_stim(8);
    st_a[0] = 1'b1; io_a[0] = 1'b0; wr_a[0] = 1'b0;
    run_seq(8);

    // I/O write with waits on cycles 2-6.
    clear_stim(14);
    st_a[0] = 1'b1; io_a[0] = 1'b1; wr_a[0] = 1'b1;
    for (int i = 2; i <= 6; i++) nwt_a[i] = 1'b0;
    run_seq(14);

    // I/O read with nwaitext held low.
    clear_stim(MAXC);
    st_a[0] = 1'b1; io_a[0] = 1'b1; wr_a[0] = 1'b0;
    for (int i = 0; i < MAXC; i++) nwt_a[i] = 1'b0;
    tail_nwt = 1'b0;
`ifdef BUS_TIMEOUT_EN
    run_seq(30);
`else
    run_seq(1002);
`endif
    pulse_reset();

    // Starts while busy are ignored; the one after HOLD is accepted.
    clear_stim(14);
    for (int i = 0; i <= 4; i++) begin
      io_a[i] = 1'b0; wr_a[i] = 1'b0;
    end
    st_a[0] = 1'b1; st_a[2] = 1'b1; st_a[3] = 1'b1; st_a[4] = 1'b1;
    run_seq(14);

    // Reset asserted during WAIT releases strobes without a clock edge.
    clear_stim(6);
    st_a[0] = 1'b1; io_a[0] = 1'b1; wr_a[0] = 1'b0;
    for (int i = 0; i < MAXC; i++) nwt_a[i] = 1'b0;
    tail_nwt = 1'b0;
    run_seq(6);
    #3;
    nreset = 1'b0;
    #1;
    cyc = -1;
    chk("async_reset", {1'b0, nmem, nio, nr, nw, busy, done, berr}, 8'b0111_1000);
    nwaitext = 1'b1;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    clear_stim(8);
    st_a[0] = 1'b1; io_a[0] = 1'b0; wr_a[0] = 1'b0;
    run_seq(8);

    // Random traffic with wait runs long enough to reach the timeout.
    for (int r = 0; r < 3; r++) random_run(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
